// File: rtl/output_stream_scheduler.sv
// output_stream_scheduler: captures 9-lane PE result batches into the output buffer, then streams the map out.
// Latency: buffer write strobe 1 cycle after pe_result_valid; streaming at one word per 2 cycles (FETCH, HOLD).
// Backpressure: m_ready low holds the word in HOLD; PE side has none, early results are dropped and flag overrun.
// Optional macro OUTBUF_SCHED_PERF_EN enables the stall_cycles counter.
module output_stream_scheduler #(
    parameter int NUM_OUTPUTS = 49,
    parameter int LANES       = 9,
    parameter int CAPTURE_GAP = 120,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              pe_result_valid,
    output logic              buf_wr_en,
    output logic [ADDR_W-1:0] buf_wr_base,
    output logic [LANES-1:0]  buf_wr_lane_mask,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    input  logic [DATA_W-1:0] buf_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done,
    output logic              overrun,
    output logic [15:0]       stall_cycles
);

    localparam int GAP_W = (CAPTURE_GAP > 1) ? $clog2(CAPTURE_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_RES, S_GAP, S_FETCH, S_HOLD, S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_base;
    logic [ADDR_W-1:0]   r_rd_idx;
    logic [GAP_W-1:0]    r_gap_cnt;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_base_out;
    logic [LANES-1:0]    r_mask;
    logic                r_m_valid;
    logic                r_m_last;
    logic [DATA_W-1:0]   r_m_data;
    logic                r_first;
    logic                r_done;
    logic                r_overrun;

    logic                w_capture;
    logic                w_drop;
    logic                w_start_acc;
    logic                w_hs;
    logic                w_last_batch;
    logic [ADDR_W:0]     w_base_ext;
    logic [LANES-1:0]    w_mask;

    // One extra bit so the end-of-map compare cannot wrap.
    assign w_base_ext   = {1'b0, r_wr_base};
    assign w_last_batch = (w_base_ext + (ADDR_W+1)'(LANES)) >= (ADDR_W+1)'(NUM_OUTPUTS);
    assign w_hs         = r_m_valid && m_ready;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mask[i] = (w_base_ext + (ADDR_W+1)'(i)) < (ADDR_W+1)'(NUM_OUTPUTS);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_drop      = 1'b0;
        w_start_acc = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_acc = 1'b1;
                    w_state_nxt = S_WAIT_RES;
                end
            end
            S_WAIT_RES: begin
                if (pe_result_valid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = w_last_batch ? S_FETCH : S_GAP;
                end
            end
            S_GAP: begin
                w_drop = pe_result_valid;
                if (r_gap_cnt == '0) begin
                    w_state_nxt = S_WAIT_RES;
                end
            end
            S_FETCH: begin
                w_drop      = pe_result_valid;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                w_drop = pe_result_valid;
                if (w_hs) begin
                    w_state_nxt = r_m_last ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                w_drop      = pe_result_valid;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_base     <= '0;
            r_rd_idx      <= '0;
            r_gap_cnt     <= '0;
            r_wr_en       <= 1'b0;
            r_wr_base_out <= '0;
            r_mask        <= '0;
            r_m_valid     <= 1'b0;
            r_m_last      <= 1'b0;
            r_m_data      <= '0;
            r_first       <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wr_en <= w_capture;
            r_first <= (r_state == S_FETCH);
            r_done  <= (r_state == S_DONE);

            if (w_start_acc) begin
                r_wr_base <= '0;
                r_rd_idx  <= '0;
                r_overrun <= 1'b0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end

            if (w_capture) begin
                r_wr_base_out <= r_wr_base;
                r_mask        <= w_mask;
                r_wr_base     <= r_wr_base + ADDR_W'(LANES);
                r_gap_cnt     <= GAP_W'(CAPTURE_GAP - 1);
                if (w_last_batch) begin
                    r_rd_idx <= '0;
                end
            end else if (r_state == S_GAP && r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end

            if (r_state == S_FETCH) begin
                r_m_valid <= 1'b1;
                r_m_last  <= (r_rd_idx == ADDR_W'(NUM_OUTPUTS - 1));
            end
            // Buffer data is only present in the first HOLD cycle; keep a copy for stalls.
            if (r_first) begin
                r_m_data <= buf_rd_data;
            end
            if (w_hs) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
                if (!r_m_last) begin
                    r_rd_idx <= r_rd_idx + 1'b1;
                end
            end
        end
    end

`ifdef OUTBUF_SCHED_PERF_EN
    logic [15:0] r_stall;

    always_ff @(posedge clk) begin
        if (reset || w_start_acc) begin
            r_stall <= '0;
        end else if (r_m_valid && !m_ready && r_stall != 16'hFFFF) begin
            r_stall <= r_stall + 16'd1;
        end
    end

    assign stall_cycles = r_stall;
`else
    assign stall_cycles = '0;
`endif

    assign buf_wr_en        = r_wr_en;
    assign buf_wr_base      = r_wr_base_out;
    assign buf_wr_lane_mask = r_mask;
    assign buf_rd_en        = (r_state == S_FETCH);
    assign buf_rd_addr      = r_rd_idx;
    assign m_valid          = r_m_valid;
    assign m_data           = r_first ? buf_rd_data : r_m_data;
    assign m_last           = r_m_last;
    assign busy             = (r_state != S_IDLE);
    assign done             = r_done;
    assign overrun          = r_overrun;

endmodule

// File: tb/tb_output_stream_scheduler.sv
// Bench for output_stream_scheduler: row table for capture phases, scoreboards for writes and stream words.
module tb_output_stream_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, pe, m_ready;
    logic        buf_wr_en, buf_rd_en, m_valid, m_last, busy, done, overrun;
    logic [11:0] buf_wr_base, buf_rd_addr;
    logic [8:0]  buf_wr_lane_mask;
    logic [31:0] m_data;
    logic [31:0] buf_rd_data = '0;
    logic [15:0] stall_cycles;

    logic        start_s, pe_s;
    logic        ones = 1'b1;
    logic        s9_wr_en, s9_rd_en, s9_valid, s9_last, s9_busy, s9_done, s9_ovr;
    logic [11:0] s9_wr_base, s9_rd_addr;
    logic [8:0]  s9_mask;
    logic [31:0] s9_data;
    logic [31:0] s9_rd_data = '0;
    logic [15:0] s9_stall;
    logic        s1_wr_en, s1_rd_en, s1_valid, s1_last, s1_busy, s1_done, s1_ovr;
    logic [11:0] s1_wr_base, s1_rd_addr;
    logic [8:0]  s1_mask;
    logic [31:0] s1_data;
    logic [31:0] s1_rd_data = '0;
    logic [15:0] s1_stall;

    output_stream_scheduler u_dut (
        .clk(clk), .reset(reset), .start(start), .pe_result_valid(pe),
        .buf_wr_en(buf_wr_en), .buf_wr_base(buf_wr_base), .buf_wr_lane_mask(buf_wr_lane_mask),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done), .overrun(overrun), .stall_cycles(stall_cycles)
    );

    output_stream_scheduler #(.NUM_OUTPUTS(9)) u_n9 (
        .clk(clk), .reset(reset), .start(start_s), .pe_result_valid(pe_s),
        .buf_wr_en(s9_wr_en), .buf_wr_base(s9_wr_base), .buf_wr_lane_mask(s9_mask),
        .buf_rd_en(s9_rd_en), .buf_rd_addr(s9_rd_addr), .buf_rd_data(s9_rd_data),
        .m_valid(s9_valid), .m_ready(ones), .m_data(s9_data), .m_last(s9_last),
        .busy(s9_busy), .done(s9_done), .overrun(s9_ovr), .stall_cycles(s9_stall)
    );

    output_stream_scheduler #(.NUM_OUTPUTS(1)) u_n1 (
        .clk(clk), .reset(reset), .start(start_s), .pe_result_valid(pe_s),
        .buf_wr_en(s1_wr_en), .buf_wr_base(s1_wr_base), .buf_wr_lane_mask(s1_mask),
        .buf_rd_en(s1_rd_en), .buf_rd_addr(s1_rd_addr), .buf_rd_data(s1_rd_data),
        .m_valid(s1_valid), .m_ready(ones), .m_data(s1_data), .m_last(s1_last),
        .busy(s1_busy), .done(s1_done), .overrun(s1_ovr), .stall_cycles(s1_stall)
    );

    function automatic logic [31:0] fdat(input logic [11:0] a);
        return 32'hBEEF_0000 ^ {a, 4'h3, a, 4'h9};
    endfunction

    // Buffer models: read data returned one cycle after the request.
    always @(posedge clk) begin
        if (buf_rd_en) buf_rd_data <= fdat(buf_rd_addr);
        if (s9_rd_en)  s9_rd_data  <= fdat(s9_rd_addr);
        if (s1_rd_en)  s1_rd_data  <= fdat(s1_rd_addr);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed { logic [11:0] base; logic [8:0] mask; } wr_t;
    typedef struct packed { logic [31:0] d; logic l; } wd_t;
    wr_t wr_q[$];
    wd_t wd_q[$];
    wr_t we;
    wd_t wx;

    int          words_seen = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_hs_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    always @(negedge clk) begin
        if (buf_wr_en) begin
            if (wr_q.size() == 0) chk("wr_unexpected", 1, 0);
            else begin
                we = wr_q.pop_front();
                chk("wr_base", buf_wr_base, we.base);
                chk("wr_mask", buf_wr_lane_mask, we.mask);
            end
        end
        if (m_valid && m_ready) begin
            if (wd_q.size() == 0) chk("word_unexpected", 1, 0);
            else begin
                wx = wd_q.pop_front();
                chk("word_data", m_data, wx.d);
                chk("word_last", m_last, wx.l);
            end
            words_seen++;
            if (m_last) last_hs_cyc = cyc;
        end
        if (prev_stall) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_d);
            chk("stall_last", m_last, prev_l);
        end
        prev_stall = m_valid && !m_ready && !reset;
        prev_d     = m_data;
        prev_l     = m_last;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    int       s9_wr_cnt = 0, s9_words = 0, s9_err = 0, s9_last_idx = -1, s9_done_cyc = 0;
    int       s1_wr_cnt = 0, s1_words = 0, s1_err = 0, s1_last_idx = -1, s1_done_cyc = 0;
    logic [8:0] s9_mask_seen = '0, s1_mask_seen = '0;

    always @(negedge clk) begin
        if (s9_wr_en) begin s9_wr_cnt++; s9_mask_seen = s9_mask; end
        if (s9_valid) begin
            if (s9_data !== fdat(12'(s9_words))) s9_err++;
            if (s9_last) s9_last_idx = s9_words;
            s9_words++;
        end
        if (s9_done) s9_done_cyc = cyc;
        if (s1_wr_en) begin s1_wr_cnt++; s1_mask_seen = s1_mask; end
        if (s1_valid) begin
            if (s1_data !== fdat(12'(s1_words))) s1_err++;
            if (s1_last) s1_last_idx = s1_words;
            s1_words++;
        end
        if (s1_done) s1_done_cyc = cyc;
    end

    typedef struct {
        bit         is_start;
        int         delay;
        bit         accept;
        logic [11:0] base;
        logic [8:0] mask;
        bit         ovr;
    } row_t;
    row_t rows[14];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk(nm, {buf_wr_en, buf_wr_base, buf_wr_lane_mask, buf_rd_en, buf_rd_addr, m_valid,
                 m_data, m_last, busy, done, overrun, stall_cycles}, 0);
    endtask

    task automatic start_layer();
        for (int i = 0; i < 49; i++) wd_q.push_back({fdat(12'(i)), i == 48});
        words_seen = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int r = lo; r <= hi; r++) begin
            repeat (rows[r].delay - 1) step();
            if (rows[r].is_start) start = 1'b1;
            else pe = 1'b1;
            if (rows[r].accept) wr_q.push_back({rows[r].base, rows[r].mask});
            step();
            start = 1'b0;
            pe    = 1'b0;
            chk($sformatf("row%0d_wr_en", r), buf_wr_en, rows[r].accept);
            chk($sformatf("row%0d_overrun", r), overrun, rows[r].ovr);
        end
    endtask

    task automatic wait_words(input int k);
        for (int i = 0; i < 400 && words_seen < k; i++) step();
        if (words_seen < k) chk("wait_words_timeout", words_seen, k);
    endtask

    task automatic finish_layer(input int dc, input bit exp_ovr);
        for (int i = 0; i < 400 && done_cnt == dc; i++) step();
        chk("done_count", done_cnt, dc + 1);
        chk("done_latency", done_cyc - last_hs_cyc, 2);
        chk("words_seen", words_seen, 49);
        chk("words_left", wd_q.size(), 0);
        chk("writes_left", wr_q.size(), 0);
        chk("layer_overrun", overrun, exp_ovr);
        chk("idle_after_done", busy, 0);
    endtask

    int dc;
    int pe_cyc;

    initial begin
        rows[0]  = '{0,   3, 1, 12'd0,  9'h1FF, 0};
        rows[1]  = '{1,  60, 0, 12'd0,  9'h000, 0};
        rows[2]  = '{0,  61, 1, 12'd9,  9'h1FF, 0};
        rows[3]  = '{0, 121, 1, 12'd18, 9'h1FF, 0};
        rows[4]  = '{0, 121, 1, 12'd27, 9'h1FF, 0};
        rows[5]  = '{0, 121, 1, 12'd36, 9'h1FF, 0};
        rows[6]  = '{0, 121, 1, 12'd45, 9'h00F, 0};
        rows[7]  = '{0,   3, 1, 12'd0,  9'h1FF, 0};
        rows[8]  = '{0,  50, 0, 12'd0,  9'h000, 1};
        rows[9]  = '{0,  71, 1, 12'd9,  9'h1FF, 1};
        rows[10] = '{0, 121, 1, 12'd18, 9'h1FF, 1};
        rows[11] = '{0, 121, 1, 12'd27, 9'h1FF, 1};
        rows[12] = '{0, 121, 1, 12'd36, 9'h1FF, 1};
        rows[13] = '{0, 121, 1, 12'd45, 9'h00F, 1};

        reset = 1'b1; start = 1'b0; pe = 1'b0; m_ready = 1'b1; start_s = 1'b0; pe_s = 1'b0;
        repeat (3) step();
        chk_all_zero("reset_outputs");
        reset = 1'b0;
        step();

        pe = 1'b1;
        step();
        pe = 1'b0;
        chk("idle_pe_wr_en", buf_wr_en, 0);
        chk("idle_pe_overrun", overrun, 0);
        chk("idle_pe_busy", busy, 0);
        repeat (2) step();

        // Clean layer, including a start pulse while busy.
        dc = done_cnt;
        start_layer();
        run_rows(0, 6);
        finish_layer(dc, 0);

        // Gap violation plus 10 cycles of backpressure on word 3.
        dc = done_cnt;
        start_layer();
        run_rows(7, 13);
        wait_words(3);
        m_ready = 1'b0;
        repeat (11) step();
        m_ready = 1'b1;
        finish_layer(dc, 1);
`ifdef OUTBUF_SCHED_PERF_EN
        chk("stall_cycles", stall_cycles, 10);
`else
        chk("stall_cycles", stall_cycles, 0);
`endif

        // Reset while word 20 is held; reset beats a simultaneous start.
        dc = done_cnt;
        start_layer();
        run_rows(0, 6);
        wait_words(20);
        m_ready = 1'b0;
        step();
        chk("hold_w20_valid", m_valid, 1);
        chk("hold_w20_data", m_data, fdat(12'd20));
        reset = 1'b1;
        start = 1'b1;
        step();
        reset = 1'b0;
        start = 1'b0;
        chk_all_zero("midrun_reset_outputs");
        wd_q.delete();
        wr_q.delete();
        m_ready = 1'b1;
        repeat (5) step();
        chk("no_done_after_reset", done_cnt, dc);
        chk("reset_beats_start", busy, 0);
        dc = done_cnt;
        start_layer();
        run_rows(0, 6);
        finish_layer(dc, 0);

        // Edge map sizes: 9 outputs (single full batch) and 1 output.
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        repeat (2) step();
        pe_s   = 1'b1;
        pe_cyc = cyc;
        step();
        pe_s = 1'b0;
        for (int i = 0; i < 60 && (s9_done_cyc == 0 || s1_done_cyc == 0); i++) step();
        chk("n9_writes", s9_wr_cnt, 1);
        chk("n9_mask", s9_mask_seen, 9'h1FF);
        chk("n9_words", s9_words, 9);
        chk("n9_last_idx", s9_last_idx, 8);
        chk("n9_data_errors", s9_err, 0);
        chk("n9_done_latency", s9_done_cyc - pe_cyc, 20);
        chk("n1_writes", s1_wr_cnt, 1);
        chk("n1_mask", s1_mask_seen, 9'h001);
        chk("n1_words", s1_words, 1);
        chk("n1_last_idx", s1_last_idx, 0);
        chk("n1_data_errors", s1_err, 0);
        chk("n1_done_latency", s1_done_cyc - pe_cyc, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
